df_config_sequencer: RTL and testbench
======================================

// Module: df_config_sequencer
// PURPOSE
//  Configuration controller for df_digital_filter. Drives its enconfig/configin strobe interface.
//  Arbitrates between two sources: a host one-shot request (valid/ready) and an autonomous
//  schedule that steps through NUM_SLOTS programmable {hp,wg[1:0]} profiles with per-slot dwell.
//  Sits between the host register/pin interface and the filter; the filter itself is unchanged.
// PARAMETERS
//  NUM_SLOTS      4   number of schedule profiles (>=2, power of two)
//  DWELL_W        16  width of per-slot dwell counter (clock cycles)
//  SETTLE_CYCLES  2   cycles enconfig/configin held low after each strobe (>=1)
// PORTS
//  CLK          in   1                  system clock (sampling clock of filter)
//  nRST         in   1                  asynchronous active-low reset
//  wr_en        in   1                  write one schedule slot this cycle
//  wr_slot      in   $clog2(NUM_SLOTS)  slot index to write
//  wr_cfg       in   3                  slot profile {hp,wg1,wg0}
//  wr_dwell     in   DWELL_W            slot dwell in cycles; 0 = hold slot indefinitely
//  run          in   1                  level: 1 = execute schedule, 0 = stop
//  req_valid    in   1                  host one-shot config request
//  req_cfg      in   3                  requested {hp,wg1,wg0}
//  req_ready    out  1                  request accepted when req_valid & req_ready
//  enconfig     out  1                  to filter enconfig (registered)
//  configin     out  3                  to filter configin (registered)
//  active_slot  out  $clog2(NUM_SLOTS)  slot currently scheduled (registered)
//  busy         out  1                  1 in APPLY/SETTLE
// BEHAVIOUR
//  - Reset (async): state IDLE, enconfig=0, configin=0, active_slot=0, busy=0, dwell cnt=0,
//    pending flag=0; slot table cleared to cfg=000, dwell=0. Reset mid-strobe drops enconfig at once.
//  - All outputs except req_ready registered; req_ready = (state==IDLE || state==DWELL), combinational.
//  - FSM IDLE/APPLY/SETTLE/DWELL:
//    IDLE:   req_valid -> accept, APPLY(req_cfg), src=MAN; else run -> active_slot=0, APPLY(slot0), src=SCH.
//    APPLY:  exactly 1 cycle enconfig=1, configin=pending cfg, busy=1 -> SETTLE.
//    SETTLE: SETTLE_CYCLES cycles enconfig=0, configin=000, busy=1. Exit:
//            pending flag set -> clear it, advance slot, APPLY(next slot);
//            else run=0 -> IDLE; src=SCH or was-in-DWELL -> DWELL, cnt=dwell[active_slot]-1; else IDLE.
//    DWELL:  run=0 -> IDLE next cycle, active_slot=0 (no strobe). dwell==0 -> stay, never advance.
//            else cnt decrements; at cnt==0 advance active_slot (NUM_SLOTS-1 wraps to 0), APPLY(slot).
//  - Latency: req_valid/run sampled at edge k -> enconfig=1 during cycle k+1.
//  - Scheduled slot period = 1 + SETTLE_CYCLES + dwell cycles.
//  - Manual request in DWELL: accepted, DWELL interrupted; after SETTLE returns to DWELL,
//    dwell of current slot restarts from full value.
//  - Simultaneous req_valid and dwell expiry: manual wins; pending flag set; next slot applied
//    immediately after manual SETTLE (back-to-back strobes separated by SETTLE_CYCLES).
//  - run falling during APPLY/SETTLE: strobe completes, then IDLE.
//  - wr_en any time: slot table updated at edge; active config not re-applied; new dwell used
//    on next load of that slot. Same-cycle write to slot being loaded: old value loaded.
// CONFIGURATION
//  DF_SEQ_WRAP_CNT_EN defined: adds output port wrap_cnt[7:0]; increments on each scheduled
//    wrap NUM_SLOTS-1 -> 0, saturates at 255, cleared when run=0 or nRST=0.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset: nRST=0 with run=1, req_valid=1 -> enconfig=0, configin=000, busy=0, active_slot=0.
//  2 Manual in IDLE: req_cfg=111 one cycle -> req_ready=1; next cycle enconfig=1, configin=111;
//    then 2 cycles enconfig=0/configin=000, busy=1; then IDLE, busy=0.
//  3 Schedule (NUM_SLOTS=2): slot0={000,5}, slot1={101,3}, run=1 -> strobe 000, strobe 101
//    8 cycles later, strobe 000 6 cycles after that, active_slot 0,1,0.
//  4 Collision: req_valid(cfg 011) on dwell-expiry cycle -> strobe 011, then strobe of next
//    slot exactly 3 cycles later; dwell hold (dwell=0) slot never advances over 1000 cycles.
//  5 Stop/reset mid-op: run=0 in DWELL -> IDLE next cycle, active_slot=0, no strobe;
//    nRST low during APPLY -> enconfig=0 within same cycle.
//  6 DF_SEQ_WRAP_CNT_EN: 3 full schedule cycles -> wrap_cnt=3; 300 cycles -> 255; run=0 -> 0.

Source files
------------

// File: rtl/df_config_sequencer.sv
// -----------------------------------------------------------------------------
// df_config_sequencer
//
// Configuration controller for df_digital_filter. Drives the filter's
// enconfig/configin strobe interface from one of two sources:
//   * a host one-shot request (req_valid/req_ready handshake), or
//   * an autonomous schedule that steps through NUM_SLOTS programmable
//     {hp,wg1,wg0} profiles, each held for its own dwell time.
// A host request always wins over the schedule.
//
// Every strobe is one APPLY cycle (enconfig=1), followed by SETTLE_CYCLES
// cycles with enconfig=0 and configin=000.
//
// Ports
//   CLK, nRST         clock and asynchronous active-low reset
//   wr_en/wr_slot/
//   wr_cfg/wr_dwell   slot table write port (dwell 0 = hold slot forever)
//   run               level, 1 = execute schedule
//   req_valid/req_cfg host one-shot request, accepted when req_ready=1
//   req_ready         combinational, 1 in IDLE and DWELL
//   enconfig/configin registered strobe to the filter
//   active_slot       registered index of the scheduled slot
//   busy              registered, 1 while in APPLY or SETTLE
//
// Build option
//   DF_SEQ_WRAP_CNT_EN  adds output wrap_cnt[7:0]: counts scheduled wraps
//                       from the last slot to slot 0, saturating at 255,
//                       cleared while run=0.
// -----------------------------------------------------------------------------
module df_config_sequencer #(
  parameter int NUM_SLOTS     = 4,
  parameter int DWELL_W       = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_SLOTS)-1:0] wr_slot,
  input  logic [2:0]                   wr_cfg,
  input  logic [DWELL_W-1:0]           wr_dwell,
  input  logic                         run,
  input  logic                         req_valid,
  input  logic [2:0]                   req_cfg,
  output logic                         req_ready,
  output logic                         enconfig,
  output logic [2:0]                   configin,
  output logic [$clog2(NUM_SLOTS)-1:0] active_slot,
  output logic                         busy
`ifdef DF_SEQ_WRAP_CNT_EN
  ,
  output logic [7:0]                   wrap_cnt
`endif
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  // Settle counter holds SETTLE_CYCLES-1 down to 0.
  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DWELL  = 2'd3
  } state_t;

  state_t              state_r;
  logic [2:0]          cfg_tab_r   [NUM_SLOTS];
  logic [DWELL_W-1:0]  dwell_tab_r [NUM_SLOTS];
  logic [DWELL_W-1:0]  cnt_r;
  logic [SC_W-1:0]     scnt_r;
  logic                hold_r;       // loaded slot had dwell 0
  logic                pending_r;    // dwell expired while a host request won
  logic                src_sch_r;    // current strobe came from the schedule
  logic                was_dwell_r;  // host request interrupted a DWELL
  logic                enconfig_r;
  logic [2:0]          configin_r;
  logic [SLOT_W-1:0]   active_slot_r;
  logic                busy_r;

  logic                req_ready_s;
  logic [SLOT_W-1:0]   next_slot_s;
  logic                expiry_s;
  logic                settle_done_s;

  // Decode handshake readiness, next slot index and end-of-phase conditions.
  always_comb begin
    req_ready_s   = (state_r == ST_IDLE) || (state_r == ST_DWELL);
    if (active_slot_r == LAST_SLOT) begin
      next_slot_s = {SLOT_W{1'b0}};
    end else begin
      next_slot_s = active_slot_r + SLOT_W'(1);
    end
    expiry_s      = (state_r == ST_DWELL) && run && !hold_r &&
                    (cnt_r == {DWELL_W{1'b0}});
    settle_done_s = (state_r == ST_SETTLE) && (scnt_r == {SC_W{1'b0}});
  end

  assign req_ready   = req_ready_s;
  assign enconfig    = enconfig_r;
  assign configin    = configin_r;
  assign active_slot = active_slot_r;
  assign busy        = busy_r;

  // Slot table: written any time; reads elsewhere see the pre-write value.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        cfg_tab_r[i]   <= 3'b000;
        dwell_tab_r[i] <= {DWELL_W{1'b0}};
      end
    end else if (wr_en) begin
      cfg_tab_r[wr_slot]   <= wr_cfg;
      dwell_tab_r[wr_slot] <= wr_dwell;
    end else begin
      cfg_tab_r   <= cfg_tab_r;
      dwell_tab_r <= dwell_tab_r;
    end
  end

  // Sequencer FSM; outputs are registered on the transition into each state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r       <= ST_IDLE;
      enconfig_r    <= 1'b0;
      configin_r    <= 3'b000;
      active_slot_r <= {SLOT_W{1'b0}};
      busy_r        <= 1'b0;
      cnt_r         <= {DWELL_W{1'b0}};
      scnt_r        <= {SC_W{1'b0}};
      hold_r        <= 1'b0;
      pending_r     <= 1'b0;
      src_sch_r     <= 1'b0;
      was_dwell_r   <= 1'b0;
    end else begin
      // The strobe lasts exactly one cycle unless re-entering APPLY below.
      enconfig_r <= 1'b0;
      configin_r <= 3'b000;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            state_r     <= ST_APPLY;
            enconfig_r  <= 1'b1;
            configin_r  <= req_cfg;
            busy_r      <= 1'b1;
            src_sch_r   <= 1'b0;
            was_dwell_r <= 1'b0;
          end else if (run) begin
            state_r       <= ST_APPLY;
            active_slot_r <= {SLOT_W{1'b0}};
            enconfig_r    <= 1'b1;
            configin_r    <= cfg_tab_r[0];
            busy_r        <= 1'b1;
            src_sch_r     <= 1'b1;
            was_dwell_r   <= 1'b0;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_APPLY: begin
          state_r <= ST_SETTLE;
          scnt_r  <= SC_W'(SETTLE_CYCLES - 1);
          busy_r  <= 1'b1;
        end
        ST_SETTLE: begin
          if (!settle_done_s) begin
            scnt_r <= scnt_r - SC_W'(1);
          end else if (pending_r && run) begin
            // Deferred dwell expiry: strobe the next slot back-to-back.
            state_r       <= ST_APPLY;
            pending_r     <= 1'b0;
            active_slot_r <= next_slot_s;
            enconfig_r    <= 1'b1;
            configin_r    <= cfg_tab_r[next_slot_s];
            src_sch_r     <= 1'b1;
            was_dwell_r   <= 1'b0;
          end else if (!run) begin
            state_r       <= ST_IDLE;
            pending_r     <= 1'b0;
            active_slot_r <= {SLOT_W{1'b0}};
            busy_r        <= 1'b0;
          end else if (src_sch_r || was_dwell_r) begin
            // Dwell (re)starts from the full value of the current slot.
            state_r   <= ST_DWELL;
            pending_r <= 1'b0;
            busy_r    <= 1'b0;
            cnt_r     <= dwell_tab_r[active_slot_r] - DWELL_W'(1);
            hold_r    <= (dwell_tab_r[active_slot_r] == {DWELL_W{1'b0}});
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_DWELL: begin
          if (req_valid) begin
            // Host wins; remember a coincident expiry so the slot still advances.
            state_r     <= ST_APPLY;
            enconfig_r  <= 1'b1;
            configin_r  <= req_cfg;
            busy_r      <= 1'b1;
            src_sch_r   <= 1'b0;
            was_dwell_r <= 1'b1;
            pending_r   <= expiry_s;
          end else if (!run) begin
            state_r       <= ST_IDLE;
            active_slot_r <= {SLOT_W{1'b0}};
          end else if (hold_r) begin
            state_r <= ST_DWELL;
          end else if (expiry_s) begin
            state_r       <= ST_APPLY;
            active_slot_r <= next_slot_s;
            enconfig_r    <= 1'b1;
            configin_r    <= cfg_tab_r[next_slot_s];
            busy_r        <= 1'b1;
            src_sch_r     <= 1'b1;
            was_dwell_r   <= 1'b0;
          end else begin
            cnt_r <= cnt_r - DWELL_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DF_SEQ_WRAP_CNT_EN
  logic       wrap_s;
  logic [7:0] wrap_cnt_r;

  // A wrap is any scheduled advance out of the last slot.
  always_comb begin
    wrap_s = ((expiry_s && !req_valid) || (settle_done_s && pending_r && run)) &&
             (active_slot_r == LAST_SLOT);
  end

  // Saturating wrap counter, held at zero while the schedule is stopped.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wrap_cnt_r <= 8'd0;
    end else if (!run) begin
      wrap_cnt_r <= 8'd0;
    end else if (wrap_s && (wrap_cnt_r != 8'd255)) begin
      wrap_cnt_r <= wrap_cnt_r + 8'd1;
    end else begin
      wrap_cnt_r <= wrap_cnt_r;
    end
  end

  assign wrap_cnt = wrap_cnt_r;
`endif

endmodule

// File: tb/tb_df_config_sequencer.sv
// Self-checking bench for df_config_sequencer. Strobes seen on enconfig are
// logged by a monitor and compared with a list of expected strobes built
// from the timing rules (strobe every 1 + SETTLE + dwell cycles, host
// requests strobe one cycle after acceptance).
module tb_df_config_sequencer;
  localparam int NS = 4;
  localparam int SW = 2;
  localparam int DW = 16;
  localparam int S  = 2;

  typedef struct packed {
    logic [31:0]   t;
    logic [2:0]    cfg;
    logic [SW-1:0] slot;
  } strobe_t;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          wr_en = 1'b0;
  logic [SW-1:0] wr_slot = '0;
  logic [2:0]    wr_cfg = 3'b000;
  logic [DW-1:0] wr_dwell = '0;
  logic          run = 1'b0;
  logic          req_valid = 1'b0;
  logic [2:0]    req_cfg = 3'b000;
  logic          req_ready, enconfig, busy;
  logic [2:0]    configin;
  logic [SW-1:0] active_slot;
`ifdef DF_SEQ_WRAP_CNT_EN
  logic [7:0]    wrap_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  strobe_t mon_q[$];
  strobe_t exp_q[$];
  logic [2:0]    mdl_cfg   [NS];
  int            mdl_dwell [NS];

  df_config_sequencer #(.NUM_SLOTS(NS), .DWELL_W(DW), .SETTLE_CYCLES(S)) dut (
    .CLK(CLK), .nRST(nRST), .wr_en(wr_en), .wr_slot(wr_slot), .wr_cfg(wr_cfg),
    .wr_dwell(wr_dwell), .run(run), .req_valid(req_valid), .req_cfg(req_cfg),
    .req_ready(req_ready), .enconfig(enconfig), .configin(configin),
    .active_slot(active_slot), .busy(busy)
`ifdef DF_SEQ_WRAP_CNT_EN
    , .wrap_cnt(wrap_cnt)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic strobe_t mk(int t, logic [2:0] c, logic [SW-1:0] s);
    return {32'(t), c, s};
  endfunction

  always @(negedge CLK) if (enconfig === 1'b1) mon_q.push_back(mk(cyc, configin, active_slot));

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic wait_cyc(int target);
    int g = 0;
    while (cyc < target && g < 6000) begin tick(); g++; end
    if (cyc < target) begin
      n_checks++; n_fail++;
      $display("FAIL wait_cyc: reached %0d, required %0d", cyc, target);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NS; i++) begin mdl_cfg[i] = 3'b000; mdl_dwell[i] = 0; end
  endtask

  task automatic write_slot(int s, logic [2:0] c, int d);
    wr_en = 1'b1; wr_slot = SW'(s); wr_cfg = c; wr_dwell = DW'(d);
    tick();
    wr_en = 1'b0;
    mdl_cfg[s] = c; mdl_dwell[s] = d;
  endtask

  // Expected scheduled strobes from a given start cycle and slot.
  task automatic build_sched(int start, int first, int count);
    int t = start;
    int s = first;
    for (int k = 0; k < count; k++) begin
      exp_q.push_back(mk(t, mdl_cfg[s], SW'(s)));
      t += 1 + S + mdl_dwell[s];
      s = (s + 1) % NS;
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; run = 1'b1; req_valid = 1'b1; req_cfg = 3'b111;
    repeat (3) @(negedge CLK);
    n_checks++; if (enconfig !== 1'b0) begin n_fail++; $display("FAIL reset_enconfig: got %b want 0", enconfig); end
    n_checks++; if (configin !== 3'b000) begin n_fail++; $display("FAIL reset_configin: got %b want 000", configin); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (active_slot !== '0) begin n_fail++; $display("FAIL reset_slot: got %0d want 0", active_slot); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    run = 1'b0; req_valid = 1'b0;
    tick(); nRST = 1'b1; clear_model();
    tick();
  endtask

  task automatic test_manual_idle();
    for (int it = 0; it < 4; it++) begin
      logic [2:0] c;
      c = (it == 0) ? 3'b111 : 3'($urandom_range(0, 7));
      req_valid = 1'b1; req_cfg = c;
      @(negedge CLK);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL man_ready: got %b want 1", req_ready); end
      tick(); req_valid = 1'b0;
      @(negedge CLK);
      n_checks++; if ({enconfig, configin, busy} !== {1'b1, c, 1'b1})
        begin n_fail++; $display("FAIL man_apply: got en=%b cfg=%b busy=%b want en=1 cfg=%b busy=1", enconfig, configin, busy, c); end
      for (int k = 0; k < S; k++) begin
        @(negedge CLK);
        n_checks++; if ({enconfig, configin, busy, req_ready} !== {1'b0, 3'b000, 1'b1, 1'b0})
          begin n_fail++; $display("FAIL man_settle%0d: got en=%b cfg=%b busy=%b rdy=%b want 0 000 1 0", k, enconfig, configin, busy, req_ready); end
      end
      @(negedge CLK);
      n_checks++; if ({enconfig, busy, req_ready} !== {1'b0, 1'b0, 1'b1})
        begin n_fail++; $display("FAIL man_idle: got en=%b busy=%b rdy=%b want 0 0 1", enconfig, busy, req_ready); end
      tick();
    end
  endtask

  task automatic test_schedule(int iter);
    int c0, t_last, k_tot;
    for (int s = 0; s < NS; s++) write_slot(s, 3'($urandom_range(0, 7)), $urandom_range(1, 6));
    if (iter == 0) begin write_slot(0, 3'b000, 5); write_slot(1, 3'b101, 3); end
    mon_q.delete(); exp_q.delete();
    k_tot = 2 * NS + 1;
    c0 = cyc; run = 1'b1;
    build_sched(c0 + 1, 0, k_tot);
    t_last = int'(exp_q[k_tot-1].t);
    wait_cyc(t_last + 1);
`ifdef DF_SEQ_WRAP_CNT_EN
    n_checks++; if (wrap_cnt !== 8'd2) begin n_fail++; $display("FAIL sched_wrap: got %0d want 2", wrap_cnt); end
`endif
    run = 1'b0;
    repeat (S + 3) tick();
    @(negedge CLK);
    n_checks++; if (mon_q.size() !== k_tot) begin n_fail++; $display("FAIL sched_count%0d: got %0d strobes want %0d", iter, mon_q.size(), k_tot); end
    for (int k = 0; k < k_tot; k++) begin
      strobe_t a;
      a = (k < mon_q.size()) ? mon_q[k] : '0;
      n_checks++; if (a !== exp_q[k]) begin n_fail++;
        $display("FAIL sched%0d_strobe%0d: got t=%0d cfg=%b slot=%0d want t=%0d cfg=%b slot=%0d",
                 iter, k, a.t, a.cfg, a.slot, exp_q[k].t, exp_q[k].cfg, exp_q[k].slot); end
    end
    n_checks++; if ({busy, active_slot} !== {1'b0, SW'(0)}) begin n_fail++; $display("FAIL sched_stop: got busy=%b slot=%0d want 0 0", busy, active_slot); end
  endtask

  task automatic test_collision();
    int c0, t0, te, t1, m, t2;
    logic [2:0] mc, mc2;
    write_slot(0, 3'($urandom_range(0, 7)), $urandom_range(1, 5));
    write_slot(1, 3'($urandom_range(0, 7)), $urandom_range(2, 6));
    write_slot(2, 3'($urandom_range(0, 7)), $urandom_range(1, 6));
    mc = 3'b011; mc2 = 3'($urandom_range(0, 7));
    mon_q.delete(); exp_q.delete();
    c0 = cyc; run = 1'b1;
    t0 = c0 + 1;
    te = t0 + S + mdl_dwell[0];          // last dwell cycle of slot 0
    t1 = te + 2 + S;                     // next slot strobes right after manual settle
    m  = t1 + S + 2;                     // manual issued in slot 1's first dwell cycle
    t2 = m + 1 + S + mdl_dwell[1];       // slot 1 dwell restarts at full length
    exp_q.push_back(mk(t0, mdl_cfg[0], SW'(0)));
    exp_q.push_back(mk(te + 1, mc, SW'(0)));
    exp_q.push_back(mk(t1, mdl_cfg[1], SW'(1)));
    exp_q.push_back(mk(m, mc2, SW'(1)));
    exp_q.push_back(mk(t2, mdl_cfg[2], SW'(2)));
    wait_cyc(te); req_valid = 1'b1; req_cfg = mc; tick(); req_valid = 1'b0;
    wait_cyc(t1 + S + 1); req_valid = 1'b1; req_cfg = mc2; tick(); req_valid = 1'b0;
    wait_cyc(t2 + 1); run = 1'b0;
    repeat (S + 3) tick();
    n_checks++; if (mon_q.size() !== 5) begin n_fail++; $display("FAIL coll_count: got %0d strobes want 5", mon_q.size()); end
    for (int k = 0; k < 5; k++) begin
      strobe_t a;
      a = (k < mon_q.size()) ? mon_q[k] : '0;
      n_checks++; if (a !== exp_q[k]) begin n_fail++;
        $display("FAIL coll_strobe%0d: got t=%0d cfg=%b slot=%0d want t=%0d cfg=%b slot=%0d",
                 k, a.t, a.cfg, a.slot, exp_q[k].t, exp_q[k].cfg, exp_q[k].slot); end
    end
    // Dwell 0 holds slot 0 forever.
    write_slot(0, 3'b110, 0);
    mon_q.delete();
    c0 = cyc; run = 1'b1;
    repeat (1000) tick();
    run = 1'b0;
    repeat (S + 2) tick();
    n_checks++; if (mon_q.size() !== 1) begin n_fail++; $display("FAIL hold_count: got %0d strobes want 1", mon_q.size()); end
    n_checks++; if (mon_q.size() < 1 || mon_q[0] !== mk(c0 + 1, 3'b110, SW'(0))) begin n_fail++;
      $display("FAIL hold_strobe: got %0d entries, first t=%0d want t=%0d cfg=110", mon_q.size(),
               (mon_q.size() > 0) ? mon_q[0].t : 32'd0, c0 + 1); end
  endtask

  task automatic test_stop_reset();
    int c0, t1;
    write_slot(0, 3'b001, 1);
    write_slot(1, 3'b010, 20);
    mon_q.delete();
    c0 = cyc; run = 1'b1;
    t1 = c0 + 1 + 1 + S + 1;
    wait_cyc(t1 + S + 3);
    run = 1'b0;
    @(negedge CLK);
    n_checks++; if ({busy, active_slot} !== {1'b0, SW'(1)}) begin n_fail++; $display("FAIL stop_dwell: got busy=%b slot=%0d want 0 1", busy, active_slot); end
    tick(); @(negedge CLK);
    n_checks++; if ({busy, active_slot, req_ready} !== {1'b0, SW'(0), 1'b1}) begin n_fail++; $display("FAIL stop_idle: got busy=%b slot=%0d rdy=%b want 0 0 1", busy, active_slot, req_ready); end
    repeat (30) tick();
    n_checks++; if (mon_q.size() !== 2) begin n_fail++; $display("FAIL stop_nostrobe: got %0d strobes want 2", mon_q.size()); end
    // Reset while the strobe is up.
    req_valid = 1'b1; req_cfg = 3'b101; tick(); req_valid = 1'b0;
    @(negedge CLK);
    n_checks++; if ({enconfig, configin} !== {1'b1, 3'b101}) begin n_fail++; $display("FAIL rst_pre: got en=%b cfg=%b want 1 101", enconfig, configin); end
    #1 nRST = 1'b0;
    #1;
    n_checks++; if ({enconfig, configin, busy} !== {1'b0, 3'b000, 1'b0}) begin n_fail++; $display("FAIL rst_apply: got en=%b cfg=%b busy=%b want 0 000 0", enconfig, configin, busy); end
    @(posedge CLK); #1 nRST = 1'b1; clear_model();
    // Cleared table: slot 0 strobes 000 and holds.
    mon_q.delete();
    c0 = cyc; run = 1'b1;
    repeat (20) tick();
    run = 1'b0; repeat (S + 2) tick();
    n_checks++; if (mon_q.size() !== 1 || mon_q[0] !== mk(c0 + 1, 3'b000, SW'(0))) begin n_fail++;
      $display("FAIL rst_table: got %0d strobes want 1 at t=%0d cfg=000", mon_q.size(), c0 + 1); end
  endtask

`ifdef DF_SEQ_WRAP_CNT_EN
  task automatic test_wrap_cnt();
    int c0, per;
    for (int s = 0; s < NS; s++) write_slot(s, 3'($urandom_range(0, 7)), 1);
    per = NS * (1 + S + 1);
    c0 = cyc; run = 1'b1;
    wait_cyc(c0 + 1 + 3 * per);
    @(negedge CLK);
    n_checks++; if (wrap_cnt !== 8'd3) begin n_fail++; $display("FAIL wrap_3: got %0d want 3", wrap_cnt); end
    wait_cyc(c0 + 1 + 260 * per);
    n_checks++; if (wrap_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_sat: got %0d want 255", wrap_cnt); end
    run = 1'b0; tick(); @(negedge CLK);
    n_checks++; if (wrap_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_clr: got %0d want 0", wrap_cnt); end
    repeat (S + 3) tick();
  endtask
`endif

  initial begin
    clear_model();
    test_reset();
    test_manual_idle();
    for (int i = 0; i < 3; i++) test_schedule(i);
    test_collision();
    test_stop_reset();
`ifdef DF_SEQ_WRAP_CNT_EN
    test_wrap_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
